// File: rtl/rr_request_encoder_if.sv
// Request/response bundle for rr_request_encoder: request pulses and flush in,
// one binary index per valid/ready transfer out, plus observability signals.
interface rr_request_encoder_if #(
    parameter int INPUT_WIDTH = 8
);
    localparam int IDX_W = $clog2(INPUT_WIDTH > 1 ? INPUT_WIDTH : 2);

    logic [INPUT_WIDTH-1:0] req_i;
    logic                   flush_i;
    logic                   ready_i;
    logic                   valid_o;
    logic [IDX_W-1:0]       index_o;
    logic [INPUT_WIDTH-1:0] pending_o;
    logic                   busy_o;

    // Driven by the event sources and the consumer.
    modport master (
        output req_i,
        output flush_i,
        output ready_i,
        input  valid_o,
        input  index_o,
        input  pending_o,
        input  busy_o
    );

    // The encoder itself.
    modport slave (
        input  req_i,
        input  flush_i,
        input  ready_i,
        output valid_o,
        output index_o,
        output pending_o,
        output busy_o
    );
endinterface

// File: rtl/rr_request_encoder.sv
// Collects sticky multi-hot request pulses and hands them out one binary index
// at a time, round-robin from a rotating start point, over a registered valid/ready.
module rr_request_encoder #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rr_request_encoder_if.slave  bus
);
    localparam int IDX_W = $clog2(INPUT_WIDTH > 1 ? INPUT_WIDTH : 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INPUT_WIDTH - 1);
    localparam logic [IDX_W:0]   WIDTH_EXT = (IDX_W + 1)'(INPUT_WIDTH);

    logic [INPUT_WIDTH-1:0] pending_reg, pending_next;
    logic                   valid_reg, valid_next;
    logic [IDX_W-1:0]       index_reg, index_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;

    logic [IDX_W-1:0]       cand [INPUT_WIDTH];
    logic [INPUT_WIDTH-1:0] hit;
    logic [IDX_W-1:0]       sel;
    logic                   sel_any;
    logic                   load;

    // Candidate gi is the line visited gi steps after ptr; the wrap is done
    // explicitly so non-power-of-two widths never search past INPUT_WIDTH-1.
    generate
        for (genvar gi = 0; gi < INPUT_WIDTH; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr_reg} + (IDX_W + 1)'(gi);
            assign cand[gi]  = (sum >= WIDTH_EXT) ? IDX_W'(sum - WIDTH_EXT)
                                                  : sum[IDX_W-1:0];
            assign hit[gi]   = pending_reg[cand[gi]];
        end
    endgenerate

    // Walk from the far end so the candidate nearest ptr is the one kept.
    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = cand[i];
                sel_any = 1'b1;
            end
        end
    end

    assign load = !valid_reg || bus.ready_i;

    always_comb begin
        pending_next = pending_reg;
        valid_next   = valid_reg;
        index_next   = index_reg;
        ptr_next     = ptr_reg;

        if (load) begin
            if (sel_any) begin
                index_next        = sel;
                valid_next        = 1'b1;
                pending_next[sel] = 1'b0;
                ptr_next          = (sel == LAST_IDX) ? '0 : sel + 1'b1;
            end else begin
                valid_next = 1'b0;
            end
        end

        // New pulses are merged after the serve-clear so a same-cycle set wins.
        pending_next = pending_next | bus.req_i;

        if (bus.flush_i) begin
            pending_next = '0;
            valid_next   = 1'b0;
            index_next   = '0;
            ptr_next     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_reg <= '0;
            valid_reg   <= 1'b0;
            index_reg   <= '0;
            ptr_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            valid_reg   <= valid_next;
            index_reg   <= index_next;
            ptr_reg     <= ptr_next;
        end
    end

    assign bus.valid_o   = valid_reg;
    assign bus.index_o   = index_reg;
    assign bus.pending_o = pending_reg;
    assign bus.busy_o    = (|pending_reg) || valid_reg;

    // Structural invariants: start point and served index stay in range, and a
    // stalled output holds still until the consumer takes it.
    a_ptr_in_range : assert property (
        @(posedge clk_i) disable iff (rst_i)
        ptr_reg <= LAST_IDX
    );

    a_index_in_range : assert property (
        @(posedge clk_i) disable iff (rst_i)
        valid_reg |-> (index_reg <= LAST_IDX)
    );

    a_hold_on_stall : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (valid_reg && !bus.ready_i && !bus.flush_i) |=> (valid_reg && $stable(index_reg))
    );
endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed bench for rr_request_encoder at width 5: stimulus pushes the expected
// served indices into a queue and an independent monitor checks every transfer.
module tb_rr_request_encoder;
    localparam int W  = 5;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_request_encoder_if #(.INPUT_WIDTH(W)) bus ();

    rr_request_encoder #(.INPUT_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] exp_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [W-1:0] r);
        bus.req_i = r;
        tick();
        bus.req_i = '0;
    endtask

    // Scoreboard monitor: a transfer is committed when valid and ready are both
    // high ahead of the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer: got index %0d, expected no transfer", bus.index_o);
            end else begin
                exp_idx = exp_q.pop_front();
                if (bus.index_o !== exp_idx) begin
                    n_fail++;
                    $display("FAIL xfer: got index %0d, expected %0d", bus.index_o, exp_idx);
                end else begin
                    $display("xfer index=%0d", bus.index_o);
                end
            end
        end
    end

    initial begin
        bus.req_i   = '0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        rst         = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_valid",   32'(bus.valid_o),   0);
        check("rst_index",   32'(bus.index_o),   0);
        check("rst_pending", 32'(bus.pending_o), 0);
        check("rst_busy",    32'(bus.busy_o),    0);

        // Single request: pending after one edge, served on the next, then idle.
        exp_q.push_back(3'd2);
        pulse(5'b00100);
        check("t1_pending", 32'(bus.pending_o), 32'b00100);
        check("t1_valid0",  32'(bus.valid_o),   0);
        check("t1_busy1",   32'(bus.busy_o),    1);
        tick();
        check("t1_valid1",  32'(bus.valid_o),   1);
        check("t1_index",   32'(bus.index_o),   2);
        tick();
        check("t1_valid_end", 32'(bus.valid_o), 0);
        check("t1_busy_end",  32'(bus.busy_o),  0);

        // From ptr=0: 1,2,4 back to back, then ptr wraps to 0 so 0 precedes 4.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd4);
        pulse(5'b10110);
        tick();
        check("t2_idx_a", 32'(bus.index_o), 1);
        tick();
        check("t2_idx_b", 32'(bus.index_o), 2);
        tick();
        check("t2_idx_c", 32'(bus.index_o), 4);
        tick();
        check("t2_valid_end", 32'(bus.valid_o), 0);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd4);
        pulse(5'b10001);
        tick(3);
        check("t2b_valid_end", 32'(bus.valid_o), 0);

        // Serving 3 moves ptr to 4, so 10001 comes out as 4 then 0.
        exp_q.push_back(3'd3);
        pulse(5'b01000);
        tick(2);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd0);
        pulse(5'b10001);
        tick(3);
        check("t3_valid_end", 32'(bus.valid_o), 0);

        // Backpressure: index 0 held for 10 cycles, then 1 and 3 drain.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        pulse(5'b01011);
        check("t4_pending_pre", 32'(bus.pending_o), 32'b01011);
        check("t4_valid_pre",   32'(bus.valid_o),   0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid",   32'(bus.valid_o),   1);
            check("t4_hold_index",   32'(bus.index_o),   0);
            check("t4_hold_pending", 32'(bus.pending_o), 32'b01010);
            if (i < 9) tick();
        end
        bus.ready_i = 1'b1;
        tick(3);
        check("t4_valid_end", 32'(bus.valid_o), 0);
        check("t4_busy_end",  32'(bus.busy_o),  0);

        // Repeat pulses on an already-pending bit are absorbed.
        bus.ready_i = 1'b0;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        pulse(5'b00001);
        tick();
        pulse(5'b00100);
        pulse(5'b00100);
        check("t5_pending", 32'(bus.pending_o), 32'b00100);
        check("t5_index",   32'(bus.index_o),   0);
        bus.ready_i = 1'b1;
        tick(3);
        check("t5_valid_end", 32'(bus.valid_o), 0);

        // A pulse on the index sitting in the stalled output re-arms it.
        bus.ready_i = 1'b0;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        pulse(5'b00100);
        tick();
        check("t5b_index",   32'(bus.index_o),   2);
        check("t5b_pending", 32'(bus.pending_o), 0);
        pulse(5'b00100);
        check("t5b_rearm", 32'(bus.pending_o), 32'b00100);
        bus.ready_i = 1'b1;
        tick(3);
        check("t5b_valid_end", 32'(bus.valid_o), 0);

        // Flush beats a same-cycle request.
        bus.ready_i = 1'b0;
        bus.req_i   = 5'b11111;
        tick(2);
        bus.req_i = '0;
        check("t6_pending_full", 32'(bus.pending_o), 32'b11111);
        check("t6_valid_full",   32'(bus.valid_o),   1);
        check("t6_index_full",   32'(bus.index_o),   3);
        bus.flush_i = 1'b1;
        bus.req_i   = 5'b00001;
        tick();
        bus.flush_i = 1'b0;
        bus.req_i   = '0;
        check("t6_flush_pending", 32'(bus.pending_o), 0);
        check("t6_flush_valid",   32'(bus.valid_o),   0);
        check("t6_flush_busy",    32'(bus.busy_o),    0);
        bus.ready_i = 1'b1;
        tick(3);
        check("t6_flush_idle", 32'(bus.busy_o), 0);

        // Reset mid-transfer behaves the same and zeroes index_o.
        exp_q.push_back(3'd2);
        pulse(5'b00100);
        tick(2);
        bus.ready_i = 1'b0;
        bus.req_i   = 5'b11111;
        tick(2);
        bus.req_i = '0;
        check("t7_index_full",   32'(bus.index_o),   3);
        check("t7_pending_full", 32'(bus.pending_o), 32'b11111);
        rst       = 1'b1;
        bus.req_i = 5'b00001;
        tick();
        rst       = 1'b0;
        bus.req_i = '0;
        check("t7_rst_pending", 32'(bus.pending_o), 0);
        check("t7_rst_valid",   32'(bus.valid_o),   0);
        check("t7_rst_busy",    32'(bus.busy_o),    0);
        check("t7_rst_index",   32'(bus.index_o),   0);
        bus.ready_i = 1'b1;
        tick(3);
        check("t7_rst_idle", 32'(bus.valid_o), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_request_encoder.md
Name: rr_request_encoder

Overview:
- Sequential counterpart to the one-hot tree decoder: collects multi-hot request pulses and returns them one at a time as binary indices.
- Each request bit is held sticky until served.
- Requests are served in round-robin order and delivered over a registered valid/ready output.
- Sits between per-line event sources (interrupt lines, per-slot done flags) and a consumer that handles one binary index per transfer.

Parameters:
- INPUT_WIDTH, default 8: number of request lines; any value >= 1, non-2^n supported.
- Derived, not overridable: IDX_W = $clog2(`max(INPUT_WIDTH, 2)).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  INPUT_WIDTH  request pulses; bit k high at an edge sets pending[k].
- flush_i  input  1  synchronous clear of all pending and output state.
- ready_i  input  1  consumer accepts index_o this cycle.
- valid_o  output  1  index_o holds a served request.
- index_o  output  IDX_W  binary index of the served request line.
- pending_o  output  INPUT_WIDTH  current pending register, for observability.
- busy_o  output  1  |pending_o | valid_o.

Behaviour:
- State:
  - pending[INPUT_WIDTH-1:0]
  - out register (valid_o, index_o)
  - ptr[IDX_W-1:0], the round-robin start point
- Reset (rst_i=1 at edge) values; reset overrides all other inputs, including mid-transfer:
  - pending=0, valid_o=0, index_o=0, ptr=0, busy_o=0.
  - A transfer in progress is lost; no handshake is implied.
- Flush (flush_i=1, rst_i=0):
  - Same clearing as reset, ptr=0.
  - Takes priority over req_i and over the handshake in the same cycle.
- load = !valid_o | ready_i (output register empty, or emptying this cycle).
- Selection (combinational, from pending only, not req_i):
  - First set bit searching ptr, ptr+1, …, INPUT_WIDTH-1, then 0, …, ptr-1.
  - sel_any = |pending.
- On each edge (no reset/flush):
  - If load & sel_any: index_o<=sel; valid_o<=1; pending[sel] cleared; ptr <= (sel==INPUT_WIDTH-1) ? 0 : sel+1.
  - If load & !sel_any: valid_o<=0; index_o holds its last value.
  - If !load: out register and ptr hold; index_o is stable while valid_o & !ready_i.
  - pending |= req_i is applied after the clear, so a set wins over a clear of the same bit in the same cycle.
- Latency:
  - req_i at edge n gives valid_o at edge n+1 at the earliest: the bit is pending after edge n and loads into the out register at edge n+1.
  - Throughput is one index per cycle with ready_i held at 1.
- Request counting:
  - Requests are not counted. A repeat pulse on an already-pending bit is absorbed (delivered once).
  - A pulse on bit k while k sits in the out register (already cleared from pending) sets pending[k] again, so k is delivered a second time.
- Wrap: ptr never takes values >= INPUT_WIDTH. The search is bounded to INPUT_WIDTH for non-2^n widths.
- INPUT_WIDTH=1:
  - IDX_W=1; index_o is always 0; ptr is constant 0.
  - valid_o behaves as a one-entry sticky flag.
- Fairness: with every line continuously requesting, each index is served exactly once per INPUT_WIDTH transfers.

Test Plan:
- W=5, after reset: req_i=5'b00100 for one cycle, ready_i=1 → valid_o=1 with index_o=2 for exactly one cycle, 2 edges after the pulse; then valid_o=0, busy_o=0, ptr=3.
- W=5, ptr=0: req_i=5'b10110 for one cycle, ready_i=1 → index_o=1, 2, 4 on consecutive cycles; ptr ends at 0 (wrap from 4).
- W=5: serve index 3 first (ptr=4), then req_i=5'b10001 → order is 4 then 0, not 0 then 4.
- W=5, backpressure: ready_i=0 with req_i=5'b01011 → index_o=0 held stable and valid_o=1 for 10 cycles, pending_o=5'b01010. Then ready_i=1 → 1, 3 delivered, then valid_o=0.
- W=5, duplicates:
  - Pulse bit 2 twice while it is pending → delivered once.
  - Pulse bit 2 while index_o=2 & valid_o & !ready_i → delivered twice in total.
- W=5, flush and reset:
  - With pending_o=5'b11111 and valid_o=1, assert flush_i with req_i=5'b00001 in the same cycle → next cycle pending_o=0, valid_o=0, busy_o=0.
  - Repeat using rst_i → identical result; index_o=0.
